// File: rtl/joypad_scan_ctrl.sv
// Joypad input conditioning: synchroniser, prescaled sample tick,
// per-bit debounce and P10-P13 falling-edge interrupt request.
module joypad_scan_ctrl #(
    parameter int CLK_DIV          = 1,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] je_raw,
    input  logic [1:0] sel,
    output logic [7:0] je_clean,
    output logic       irq_joypad,
    output logic       sample_tick
);

    localparam int CW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SAMPLES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [7:0]    s1_q, s2_q;
    logic [7:0]    clean_q, clean_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q [8];
    logic [CW-1:0] cnt_d [8];
    logic          tick;
    logic [3:0]    line;
    logic [3:0]    prev_q;
    logic          irq_q, irq_d;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // A bit flips only after it has differed on DEBOUNCE_SAMPLES consecutive ticks.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (s2_q[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        line = 4'hF;
        unique case (sel)
            2'b11: line = 4'hF;
            2'b10: line = clean_q[3:0];
            2'b01: line = clean_q[7:4];
            2'b00: line = clean_q[3:0] & clean_q[7:4];
        endcase
        irq_d = |(prev_q & ~line);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 8'hFF;
            s2_q    <= 8'hFF;
            clean_q <= 8'hFF;
            div_q   <= '0;
            prev_q  <= 4'hF;
            irq_q   <= 1'b0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            s1_q    <= je_raw;
            s2_q    <= s1_q;
            clean_q <= clean_d;
            div_q   <= div_d;
            prev_q  <= line;
            irq_q   <= irq_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign je_clean    = clean_q;
    assign irq_joypad  = irq_q;
    assign sample_tick = tick;

endmodule

// File: tb/tb_joypad_scan_ctrl.sv
// Bench for joypad_scan_ctrl: directed plan plus randomized stimulus
// checked against a sample-history reference model (two parameter sets).
module tb_joypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] je_raw = 8'h00;
    logic [1:0] sel = 2'b11;
    logic [7:0] clean0, clean1;
    logic       irq0, irq1, tk0, tk1;

    int tests = 0;
    int fails = 0;
    bit armed = 0;

    always #5 clk = ~clk;

    joypad_scan_ctrl #(.CLK_DIV(1), .DEBOUNCE_SAMPLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .je_raw(je_raw), .sel(sel),
        .je_clean(clean0), .irq_joypad(irq0), .sample_tick(tk0)
    );

    joypad_scan_ctrl #(.CLK_DIV(3), .DEBOUNCE_SAMPLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .je_raw(je_raw), .sel(sel),
        .je_clean(clean1), .irq_joypad(irq1), .sample_tick(tk1)
    );

    // Reference model: each bit keeps a history of its tick samples and
    // flips once the latest DS samples all disagree with the clean value.
    int         CD [2] = '{1, 3};
    int         DS [2] = '{4, 2};
    logic [7:0] m_s1, m_s2;
    logic [7:0] m_clean [2];
    int         m_div [2];
    logic [7:0] hist [2][8];
    int         nv [2][8];
    logic [3:0] m_prev [2];
    logic       m_irq [2];

    function automatic logic [3:0] line_of(logic [7:0] c, logic [1:0] s);
        case (s)
            2'b11:   return 4'hF;
            2'b10:   return c[3:0];
            2'b01:   return c[7:4];
            default: return c[3:0] & c[7:4];
        endcase
    endfunction

    task automatic model_edge();
        logic [3:0] lo;
        logic [7:0] mask;
        bit         tk;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_clean[k] = 8'hFF;
                m_div[k]   = 0;
                m_prev[k]  = 4'hF;
                m_irq[k]   = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    hist[k][i] = 8'h00;
                    nv[k][i]   = 0;
                end
            end else begin
                tk = (m_div[k] == CD[k] - 1);
                lo = line_of(m_clean[k], sel);
                m_irq[k]  = |(m_prev[k] & ~lo);
                m_prev[k] = lo;
                if (tk) begin
                    mask = 8'((1 << DS[k]) - 1);
                    for (int i = 0; i < 8; i++) begin
                        hist[k][i] = {hist[k][i][6:0], m_s2[i]};
                        if (nv[k][i] < 8) nv[k][i]++;
                        if (nv[k][i] >= DS[k] &&
                            (hist[k][i] & mask) == (m_clean[k][i] ? 8'h00 : mask))
                            m_clean[k][i] = m_s2[i];
                    end
                end
                m_div[k] = tk ? 0 : m_div[k] + 1;
            end
        end
        if (!rst_n) begin
            m_s1 = 8'hFF;
            m_s2 = 8'hFF;
        end else begin
            m_s2 = m_s1;
            m_s1 = je_raw;
        end
    endtask

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (armed) begin
            chk("m0_clean", clean0, m_clean[0]);
            chk("m0_irq", {7'd0, irq0}, {7'd0, m_irq[0]});
            chk("m0_tick", {7'd0, tk0}, {7'd0, m_div[0] == CD[0] - 1});
            chk("m1_clean", clean1, m_clean[1]);
            chk("m1_irq", {7'd0, irq1}, {7'd0, m_irq[1]});
            chk("m1_tick", {7'd0, tk1}, {7'd0, m_div[1] == CD[1] - 1});
        end
    endtask

    initial begin
        int n;
        int lat;

        rst_n = 1'b0; je_raw = 8'h00; sel = 2'b11;
        repeat (3) begin
            step();
            armed = 1;
            chk("rst_clean", clean0, 8'hFF);
            chk("rst_irq", {7'd0, irq0}, 8'h00);
            chk("rst_tick", {7'd0, tk1}, 8'h00);
        end
        rst_n = 1'b1;
        repeat (8) step();
        chk("rel_clean", clean0, 8'h00);

        je_raw = 8'hFF; sel = 2'b10;
        repeat (12) step();
        chk("idle_clean", clean0, 8'hFF);

        je_raw = 8'hFE;
        for (int e = 0; e < 8; e++) begin
            step();
            chk("press_clean", clean0, (e >= 5) ? 8'hFE : 8'hFF);
            chk("press_irq", {7'd0, irq0}, (e == 6) ? 8'h01 : 8'h00);
        end
        je_raw = 8'hFF;
        repeat (8) step();

        sel = 2'b01; je_raw = 8'hEF;
        repeat (3) step();
        je_raw = 8'hFF;
        repeat (8) begin
            step();
            chk("glitch_clean", clean0, 8'hFF);
            chk("glitch_irq", {7'd0, irq0}, 8'h00);
        end

        sel = 2'b10; je_raw = 8'hEF;
        repeat (8) step();
        chk("held_clean", clean0, 8'hEF);
        sel = 2'b01;
        step();
        chk("sel_irq_hi", {7'd0, irq0}, 8'h01);
        step();
        chk("sel_irq_lo", {7'd0, irq0}, 8'h00);
        sel = 2'b11;
        repeat (3) begin
            step();
            chk("sel_rise_irq", {7'd0, irq0}, 8'h00);
        end

        n = 0;
        repeat (9) begin
            step();
            n += int'(tk1);
        end
        chk("tick_count", 8'(n), 8'd3);

        je_raw = 8'hFF;
        repeat (12) step();
        je_raw = 8'hFE;
        lat = -1;
        for (int e = 0; e < 12; e++) begin
            step();
            if (lat < 0 && clean1[0] == 1'b0) lat = e;
        end
        chk("pre_lat_ok", {7'd0, lat >= 5 && lat <= 7}, 8'h01);

        je_raw = 8'hFF;
        repeat (12) step();
        je_raw = 8'h7F;
        repeat (4) step();
        rst_n = 1'b0;
        repeat (2) begin
            step();
            chk("midrst_clean", clean0, 8'hFF);
            chk("midrst_irq", {7'd0, irq0}, 8'h00);
        end
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            chk("midrst_relat", clean0, (e >= 5) ? 8'h7F : 8'hFF);
        end

        for (int s = 0; s < 60; s++) begin
            je_raw = 8'($urandom);
            sel    = 2'($urandom);
            rst_n  = ($urandom_range(0, 19) != 0);
            repeat ($urandom_range(1, 12)) step();
        end
        rst_n = 1'b1;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
